// File: rtl/simple_dma_read_controller.sv
`default_nettype none
// ============================================================================
// Module      : simple_dma_read_controller
// Description : Streaming read-DMA engine. Issues 8-beat FSAB reads over a
//               programmable circular byte region into a local FIFO and pops
//               one 64-bit word per consumer request. Configured over SPAM.
//               Optional build macro DMAC_UNDERFLOW_COUNT_EN adds a
//               saturating UNDERFLOW counter register at offset 0x10.
// Revision    : 1.0 - initial release
// ============================================================================
module simple_dma_read_controller #(
    parameter logic [3:0]  FSAB_DID             = 4'h0,
    parameter logic [3:0]  FSAB_SUBDID          = 4'h0,
    parameter logic [3:0]  SPAM_DID             = 4'h0,
    parameter logic [23:0] SPAM_ADDRPFX         = 24'h000000,
    parameter logic [23:0] SPAM_ADDRMASK        = 24'h000000,
    parameter int          FIFO_DEPTH           = 16,
    parameter logic [30:0] DEFAULT_LEN          = 31'h100,
    parameter int          FSAB_INITIAL_CREDITS = 4
) (
    input  logic        core_clk,
    input  logic        core_rst_b,
    output logic        dmac__fsabo_valid,
    output logic        dmac__fsabo_mode,
    output logic [3:0]  dmac__fsabo_did,
    output logic [3:0]  dmac__fsabo_subdid,
    output logic [30:0] dmac__fsabo_addr,
    output logic [2:0]  dmac__fsabo_len,
    output logic [63:0] dmac__fsabo_data,
    output logic [7:0]  dmac__fsabo_mask,
    input  logic        dmac__fsabo_credit,
    input  logic        fsabi_valid,
    input  logic [3:0]  fsabi_did,
    input  logic [3:0]  fsabi_subdid,
    input  logic [63:0] fsabi_data,
    input  logic        spamo_valid,
    input  logic        spamo_r_nw,
    input  logic [3:0]  spamo_did,
    input  logic [23:0] spamo_addr,
    input  logic [31:0] spamo_data,
    output logic        dmac__spami_busy_b,
    output logic [31:0] dmac__spami_data,
    input  logic        request,
    output logic [63:0] data,
    output logic        data_ready
);

    localparam int c_ptr_w   = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w   = c_ptr_w + 1;
    localparam int c_occ_w   = c_ptr_w + 2;
    localparam int c_cred_w  = $clog2(FSAB_INITIAL_CREDITS + 1);
    // Stale beats can never exceed what the credits and FIFO allow in flight
    localparam int c_stale_w = $clog2(FSAB_INITIAL_CREDITS * 8 + FIFO_DEPTH + 1);

    localparam logic [c_cred_w-1:0] c_cred_max = c_cred_w'(FSAB_INITIAL_CREDITS);
    localparam logic [c_cred_w-1:0] c_cred_one = c_cred_w'(1);
    localparam logic [c_ptr_w-1:0]  c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0]  c_burst    = c_cnt_w'(8);
    localparam logic [c_occ_w-1:0]  c_occ_lim  = c_occ_w'(FIFO_DEPTH);
    localparam logic [30:0]         c_blk      = 31'd64;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [30:6]          r_next_start;
    logic [30:6]          r_next_len;
    logic [30:0]          r_cur_addr;
    logic [30:0]          r_region_start;
    logic [30:0]          r_region_end;
    logic                 r_active;
    logic [c_cred_w-1:0]  r_credits;
    logic [c_cnt_w-1:0]   r_outstanding;
    logic [c_stale_w-1:0] r_stale;
    logic [63:0]          r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_fsabo_valid;
    logic [3:0]           r_fsabo_did;
    logic [3:0]           r_fsabo_subdid;
    logic [30:0]          r_fsabo_addr;
    logic [63:0]          r_data;
    logic                 r_data_ready;
`ifdef DMAC_UNDERFLOW_COUNT_EN
    logic [31:0]          r_underflow;
`endif

    // ------------------------------------------------------------------------
    // SPAM decode
    // ------------------------------------------------------------------------
    logic        w_spam_hit;
    logic        w_spam_wr;
    logic [2:0]  w_reg_sel;
    logic        w_wr_ctrl;
    logic        w_start;
    logic        w_stop;
    logic [31:0] w_rd_data;
    logic        w_fifo_empty;
    logic [30:0] w_eff_len;
    logic [30:0] w_next_start_addr;

    assign w_spam_hit = spamo_valid && (spamo_did == SPAM_DID) &&
                        ((spamo_addr & SPAM_ADDRMASK) == SPAM_ADDRPFX);
    assign w_spam_wr  = w_spam_hit && !spamo_r_nw;

`ifdef DMAC_UNDERFLOW_COUNT_EN
    assign w_reg_sel = spamo_addr[4:2];
`else
    // Offset 0x10 folds back onto NEXT_START in the narrow decode
    assign w_reg_sel = {1'b0, spamo_addr[3:2]};
`endif

    assign w_wr_ctrl = w_spam_wr && (w_reg_sel == 3'd3);
    // Stop takes priority when both control bits are written together
    assign w_stop    = w_wr_ctrl && spamo_data[0];
    assign w_start   = w_wr_ctrl && spamo_data[1] && !spamo_data[0];

    assign w_fifo_empty      = (r_count == '0);
    assign w_next_start_addr = {r_next_start, 6'b0};
    // A zero length still describes one 64-byte block
    assign w_eff_len         = (r_next_len == '0) ? c_blk : {r_next_len, 6'b0};

    // Combinational register read mux; zero unless this is a read hit
    always_comb begin
        w_rd_data = 32'h0;
        if (w_spam_hit && spamo_r_nw) begin
            case (w_reg_sel)
                3'd0:    w_rd_data = {1'b0, r_next_start, 6'b0};
                3'd1:    w_rd_data = {1'b0, r_next_len, 6'b0};
                3'd2:    w_rd_data = {1'b0, r_cur_addr};
                3'd3:    w_rd_data = {r_active, 30'b0, w_fifo_empty};
`ifdef DMAC_UNDERFLOW_COUNT_EN
                3'd4:    w_rd_data = r_underflow;
`endif
                default: w_rd_data = 32'h0;
            endcase
        end
    end

    assign dmac__spami_busy_b = w_spam_hit;
    assign dmac__spami_data   = w_rd_data;

    // ------------------------------------------------------------------------
    // Issue and return-beat qualification
    // ------------------------------------------------------------------------
    logic [c_occ_w-1:0] w_occupancy;
    logic               w_issue;
    logic [30:0]        w_addr_inc;
    logic [30:0]        w_addr_next;
    logic               w_beat_match;
    logic               w_beat_drop;
    logic               w_beat_live;
    logic               w_push;
    logic               w_pop;

    // Space must exist for every beat already requested plus a full burst
    assign w_occupancy = c_occ_w'(r_count) + c_occ_w'(r_outstanding) + c_occ_w'(c_burst);
    assign w_issue     = r_active && (r_credits != '0) && (w_occupancy <= c_occ_lim) &&
                         !r_fsabo_valid && !w_start && !w_stop;

    assign w_addr_inc  = r_cur_addr + c_blk;
    assign w_addr_next = (w_addr_inc == r_region_end) ? r_region_start : w_addr_inc;

    // Beats from a stopped transfer are consumed first; beats with nothing
    // outstanding (e.g. in flight across a reset) are ignored
    assign w_beat_match = fsabi_valid && (fsabi_did == FSAB_DID) && (fsabi_subdid == FSAB_SUBDID);
    assign w_beat_drop  = w_beat_match && (r_stale != '0);
    assign w_beat_live  = w_beat_match && (r_stale == '0) && (r_outstanding != '0);
    assign w_push       = w_beat_live && !w_stop;
    assign w_pop        = request && !w_fifo_empty && !w_stop;

    // Programmable next-region registers
    always_ff @(posedge core_clk or negedge core_rst_b) begin
        if (!core_rst_b) begin
            r_next_start <= '0;
            r_next_len   <= DEFAULT_LEN[30:6];
        end else if (w_spam_wr) begin
            if (w_reg_sel == 3'd0) r_next_start <= spamo_data[30:6];
            if (w_reg_sel == 3'd1) r_next_len   <= spamo_data[30:6];
        end
    end

    // Transfer activity and circular address walk
    always_ff @(posedge core_clk or negedge core_rst_b) begin
        if (!core_rst_b) begin
            r_active       <= 1'b0;
            r_cur_addr     <= '0;
            r_region_start <= '0;
            r_region_end   <= '0;
        end else if (w_stop) begin
            r_active <= 1'b0;
        end else if (w_start) begin
            r_active       <= 1'b1;
            r_cur_addr     <= w_next_start_addr;
            r_region_start <= w_next_start_addr;
            r_region_end   <= w_next_start_addr + w_eff_len;
        end else if (w_issue) begin
            r_cur_addr <= w_addr_next;
        end
    end

    // Registered FSAB request strobe; fields are zero when idle
    always_ff @(posedge core_clk or negedge core_rst_b) begin
        if (!core_rst_b) begin
            r_fsabo_valid  <= 1'b0;
            r_fsabo_did    <= 4'h0;
            r_fsabo_subdid <= 4'h0;
            r_fsabo_addr   <= '0;
        end else begin
            r_fsabo_valid  <= w_issue;
            r_fsabo_did    <= w_issue ? FSAB_DID : 4'h0;
            r_fsabo_subdid <= w_issue ? FSAB_SUBDID : 4'h0;
            r_fsabo_addr   <= w_issue ? r_cur_addr : 31'h0;
        end
    end

    // Request credits, returned one per pulse and capped at the initial pool
    always_ff @(posedge core_clk or negedge core_rst_b) begin
        if (!core_rst_b) begin
            r_credits <= c_cred_max;
        end else begin
            case ({w_issue, dmac__fsabo_credit})
                2'b10:   r_credits <= r_credits - c_cred_one;
                2'b01:   if (r_credits < c_cred_max) r_credits <= r_credits + c_cred_one;
                default: r_credits <= r_credits;
            endcase
        end
    end

    // Live and stale in-flight beat accounting
    always_ff @(posedge core_clk or negedge core_rst_b) begin
        if (!core_rst_b) begin
            r_outstanding <= '0;
            r_stale       <= '0;
        end else if (w_stop) begin
            r_outstanding <= '0;
            r_stale       <= r_stale + c_stale_w'(r_outstanding)
                             - c_stale_w'(w_beat_drop) - c_stale_w'(w_beat_live);
        end else begin
            r_outstanding <= r_outstanding + (w_issue ? c_burst : c_cnt_w'(0))
                             - (w_beat_live ? c_cnt_one : c_cnt_w'(0));
            if (w_beat_drop) r_stale <= r_stale - c_stale_w'(1);
        end
    end

    // FIFO pointers and fill count; stop flushes
    always_ff @(posedge core_clk or negedge core_rst_b) begin
        if (!core_rst_b) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_stop) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are only meaningful below the fill count
    always_ff @(posedge core_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= fsabi_data;
    end

    // Consumer output word and its one-cycle strobe
    always_ff @(posedge core_clk or negedge core_rst_b) begin
        if (!core_rst_b) begin
            r_data       <= '0;
            r_data_ready <= 1'b0;
        end else begin
            r_data_ready <= w_pop;
            if (w_pop) r_data <= r_mem[r_rd_ptr];
        end
    end

`ifdef DMAC_UNDERFLOW_COUNT_EN
    // Saturating count of requests seen while the FIFO was empty
    always_ff @(posedge core_clk or negedge core_rst_b) begin
        if (!core_rst_b) begin
            r_underflow <= '0;
        end else if (w_spam_wr && (w_reg_sel == 3'd4)) begin
            r_underflow <= '0;
        end else if (request && w_fifo_empty && (r_underflow != 32'hFFFF_FFFF)) begin
            r_underflow <= r_underflow + 32'd1;
        end
    end
`endif

    assign dmac__fsabo_valid  = r_fsabo_valid;
    assign dmac__fsabo_mode   = 1'b0;
    assign dmac__fsabo_did    = r_fsabo_did;
    assign dmac__fsabo_subdid = r_fsabo_subdid;
    assign dmac__fsabo_addr   = r_fsabo_addr;
    assign dmac__fsabo_len    = 3'd0;
    assign dmac__fsabo_data   = 64'h0;
    assign dmac__fsabo_mask   = 8'h0;
    assign data               = r_data;
    assign data_ready         = r_data_ready;

    // Write-data bits with no storage behind them
    logic w_unused;
    assign w_unused = &{1'b0, spamo_data[31], spamo_data[5:2]};

endmodule
`default_nettype wire

// File: tb/tb_simple_dma_read_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_simple_dma_read_controller
// Description : Directed self-checking bench for simple_dma_read_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simple_dma_read_controller;

    localparam logic [23:0] c_base = 24'h00A000;

    logic        core_clk = 1'b0;
    logic        core_rst_b;
    logic        dmac__fsabo_valid;
    logic        dmac__fsabo_mode;
    logic [3:0]  dmac__fsabo_did;
    logic [3:0]  dmac__fsabo_subdid;
    logic [30:0] dmac__fsabo_addr;
    logic [2:0]  dmac__fsabo_len;
    logic [63:0] dmac__fsabo_data;
    logic [7:0]  dmac__fsabo_mask;
    logic        dmac__fsabo_credit;
    logic        fsabi_valid;
    logic [3:0]  fsabi_did;
    logic [3:0]  fsabi_subdid;
    logic [63:0] fsabi_data;
    logic        spamo_valid;
    logic        spamo_r_nw;
    logic [3:0]  spamo_did;
    logic [23:0] spamo_addr;
    logic [31:0] spamo_data;
    logic        dmac__spami_busy_b;
    logic [31:0] dmac__spami_data;
    logic        request;
    logic [63:0] data;
    logic        data_ready;

    simple_dma_read_controller #(
        .FSAB_DID      (4'h3),
        .FSAB_SUBDID   (4'h5),
        .SPAM_DID      (4'h2),
        .SPAM_ADDRPFX  (24'h00A000),
        .SPAM_ADDRMASK (24'hFFF000)
    ) u_dut (
        .core_clk           (core_clk),
        .core_rst_b         (core_rst_b),
        .dmac__fsabo_valid  (dmac__fsabo_valid),
        .dmac__fsabo_mode   (dmac__fsabo_mode),
        .dmac__fsabo_did    (dmac__fsabo_did),
        .dmac__fsabo_subdid (dmac__fsabo_subdid),
        .dmac__fsabo_addr   (dmac__fsabo_addr),
        .dmac__fsabo_len    (dmac__fsabo_len),
        .dmac__fsabo_data   (dmac__fsabo_data),
        .dmac__fsabo_mask   (dmac__fsabo_mask),
        .dmac__fsabo_credit (dmac__fsabo_credit),
        .fsabi_valid        (fsabi_valid),
        .fsabi_did          (fsabi_did),
        .fsabi_subdid       (fsabi_subdid),
        .fsabi_data         (fsabi_data),
        .spamo_valid        (spamo_valid),
        .spamo_r_nw         (spamo_r_nw),
        .spamo_did          (spamo_did),
        .spamo_addr         (spamo_addr),
        .spamo_data         (spamo_data),
        .dmac__spami_busy_b (dmac__spami_busy_b),
        .dmac__spami_data   (dmac__spami_data),
        .request            (request),
        .data               (data),
        .data_ready         (data_ready)
    );

    always #5 core_clk = ~core_clk;

    int checks    = 0;
    int passes    = 0;
    int fails     = 0;
    int req_count = 0;

    logic [31:0] rd_val;
    logic        rd_busy;

    // Count request strobes as they are seen between clock edges
    always @(negedge core_clk) begin
        if (core_rst_b === 1'b1 && dmac__fsabo_valid === 1'b1) req_count++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic spam_access(input logic r_nw, input logic [3:0] did, input logic [23:0] addr,
                               input logic [31:0] wdata, output logic [31:0] rdata, output logic busy);
        spamo_valid = 1'b1;
        spamo_r_nw  = r_nw;
        spamo_did   = did;
        spamo_addr  = addr;
        spamo_data  = wdata;
        #1;
        rdata = dmac__spami_data;
        busy  = dmac__spami_busy_b;
        @(negedge core_clk);
        spamo_valid = 1'b0;
        spamo_r_nw  = 1'b0;
        spamo_data  = 32'h0;
    endtask

    task automatic reg_write(input logic [7:0] off, input logic [31:0] wdata);
        logic [31:0] rd;
        logic        bz;
        spam_access(1'b0, 4'h2, c_base | {16'h0, off}, wdata, rd, bz);
    endtask

    task automatic reg_read(input string tag, input logic [7:0] off, input logic [31:0] exp);
        logic [31:0] rd;
        logic        bz;
        spam_access(1'b1, 4'h2, c_base | {16'h0, off}, 32'h0, rd, bz);
        check(tag, {32'h0, rd}, {32'h0, exp});
    endtask

    task automatic send_beats(input logic [3:0] did, input logic [3:0] sub, input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fsabi_valid  = 1'b1;
            fsabi_did    = did;
            fsabi_subdid = sub;
            fsabi_data   = base + 64'(i);
            @(negedge core_clk);
        end
        fsabi_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [63:0] exp);
        request = 1'b1;
        @(negedge core_clk);
        check({tag, "_rdy"}, {63'h0, data_ready}, 64'h1);
        check(tag, data, exp);
        request = 1'b0;
        @(negedge core_clk);
        check({tag, "_rdy_off"}, {63'h0, data_ready}, 64'h0);
    endtask

    task automatic pop_range(input string tag, input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) pop_check($sformatf("%s_%0d", tag, i), base + 64'(i));
    endtask

    task automatic pop_none(input string tag);
        request = 1'b1;
        @(negedge core_clk);
        check(tag, {63'h0, data_ready}, 64'h0);
        request = 1'b0;
        @(negedge core_clk);
    endtask

    task automatic pulse_credits(input int n);
        for (int i = 0; i < n; i++) begin
            dmac__fsabo_credit = 1'b1;
            @(negedge core_clk);
        end
        dmac__fsabo_credit = 1'b0;
    endtask

    task automatic wait_req(input string tag, input logic [30:0] exp_addr);
        for (int k = 0; k < 60 && dmac__fsabo_valid !== 1'b1; k++) @(negedge core_clk);
        check({tag, "_valid"}, {63'h0, dmac__fsabo_valid}, 64'h1);
        check({tag, "_addr"}, {33'h0, dmac__fsabo_addr}, {33'h0, exp_addr});
        check({tag, "_did"}, {56'h0, dmac__fsabo_did, dmac__fsabo_subdid}, 64'h35);
        check({tag, "_len_mode"}, {60'h0, dmac__fsabo_len, dmac__fsabo_mode}, 64'h0);
        @(negedge core_clk);
    endtask

    task automatic idle_none(input string tag, input int n);
        int c0;
        c0 = req_count;
        repeat (n) @(negedge core_clk);
        check(tag, 64'(req_count), 64'(c0));
    endtask

    initial begin
        core_rst_b         = 1'b0;
        dmac__fsabo_credit = 1'b0;
        fsabi_valid        = 1'b0;
        fsabi_did          = 4'h0;
        fsabi_subdid       = 4'h0;
        fsabi_data         = 64'h0;
        spamo_valid        = 1'b0;
        spamo_r_nw         = 1'b0;
        spamo_did          = 4'h0;
        spamo_addr         = 24'h0;
        spamo_data         = 32'h0;
        request            = 1'b0;
        repeat (3) @(negedge core_clk);

        // Reset state
        check("rst_fsabo", {dmac__fsabo_valid, dmac__fsabo_did, dmac__fsabo_subdid, dmac__fsabo_addr}, 64'h0);
        check("rst_data", data, 64'h0);
        check("rst_misc", {60'h0, data_ready, dmac__spami_busy_b, dmac__fsabo_mode, |dmac__fsabo_data}, 64'h0);
        core_rst_b = 1'b1;
        @(negedge core_clk);
        reg_read("rst_next_start", 8'h0, 32'h0);
        reg_read("rst_next_len", 8'h4, 32'h100);
        reg_read("rst_cur_addr", 8'h8, 32'h0);
        reg_read("rst_control", 8'hC, 32'h1);
        idle_none("rst_no_req", 10);

        // Start with default region; FIFO capacity limits to two bursts
        reg_write(8'hC, 32'h2);
        wait_req("req0", 31'h00);
        wait_req("req1", 31'h40);
        idle_none("cap_two_bursts", 20);
        reg_read("cur_after_two", 8'h8, 32'h80);

        // Non-matching returns are ignored
        send_beats(4'h3, 4'h4, 64'h100, 8);
        send_beats(4'h2, 4'h5, 64'h200, 8);
        reg_read("bad_beats_empty", 8'hC, 32'h8000_0001);
        pop_none("bad_beats_no_data");

        // Fill FIFO to 16 words; no new request until 8 are popped
        send_beats(4'h3, 4'h5, 64'h0, 16);
        idle_none("full_no_req", 20);
        reg_read("full_not_empty", 8'hC, 32'h8000_0000);
        pop_range("pop_a", 64'h0, 7);
        idle_none("nine_left_no_req", 10);
        pop_check("pop_a_7", 64'h7);
        wait_req("req2", 31'h80);

        send_beats(4'h3, 4'h5, 64'h10, 8);
        pop_range("pop_b", 64'h8, 8);
        wait_req("req3", 31'hC0);

        // Credits exhausted: room exists but no request until a credit returns
        send_beats(4'h3, 4'h5, 64'h18, 8);
        pop_range("pop_c", 64'h10, 8);
        idle_none("no_credit_no_req", 20);
        check("data_hold", data, 64'h17);
        pulse_credits(1);
        wait_req("req4_wrap", 31'h00);

        // Stop flushes the FIFO and discards late beats
        reg_write(8'hC, 32'h1);
        reg_read("stop_control", 8'hC, 32'h1);
        pop_none("stop_no_data");
        send_beats(4'h3, 4'h5, 64'h200, 8);
        reg_read("late_dropped", 8'hC, 32'h1);
        pop_none("late_no_data");
        pulse_credits(6);
        idle_none("stopped_no_req", 20);

        // Register access, masking and decode
        reg_write(8'h0, 32'h1234);
        reg_read("start_low_bits", 8'h0, 32'h1200);
        reg_write(8'h0, 32'h1000);
        spam_access(1'b0, 4'h1, c_base, 32'h5000, rd_val, rd_busy);
        check("wrong_did_wr_busy", {63'h0, rd_busy}, 64'h0);
        spam_access(1'b1, 4'h1, c_base, 32'h0, rd_val, rd_busy);
        check("wrong_did_rd", {31'h0, rd_busy, rd_val}, 64'h0);
        spam_access(1'b1, 4'h2, 24'h00B000, 32'h0, rd_val, rd_busy);
        check("wrong_pfx_rd", {31'h0, rd_busy, rd_val}, 64'h0);
        spam_access(1'b1, 4'h2, c_base, 32'h0, rd_val, rd_busy);
        check("start_rd_ack", {31'h0, rd_busy, rd_val}, 64'h1_0000_1000);
        reg_write(8'h4, 32'h80);
        reg_read("len_rd", 8'h4, 32'h80);

        // New two-block region; credit pool saturated at four
        reg_write(8'hC, 32'h2);
        wait_req("r2_req0", 31'h1000);
        wait_req("r2_req1", 31'h1040);
        send_beats(4'h3, 4'h5, 64'h300, 8);
        pop_range("pop_d", 64'h300, 8);
        wait_req("r2_req2", 31'h1000);
        send_beats(4'h3, 4'h5, 64'h308, 8);
        pop_range("pop_e", 64'h308, 8);
        wait_req("r2_req3", 31'h1040);
        send_beats(4'h3, 4'h5, 64'h310, 8);
        pop_range("pop_f", 64'h310, 8);
        idle_none("credit_saturated", 20);

        // Stop mid-burst
        reg_write(8'hC, 32'h1);
        reg_read("midstop_control", 8'hC, 32'h1);
        send_beats(4'h3, 4'h5, 64'h400, 8);
        reg_read("midstop_dropped", 8'hC, 32'h1);
        pulse_credits(1);
        idle_none("midstop_no_req", 20);
        reg_read("midstop_cur", 8'h8, 32'h1000);

`ifdef DMAC_UNDERFLOW_COUNT_EN
        reg_write(8'h10, 32'hFFFF_FFFF);
        pop_none("uf_0");
        pop_none("uf_1");
        pop_none("uf_2");
        reg_read("underflow_cnt", 8'h10, 32'h3);
`else
        pop_none("uf_0");
        pop_none("uf_1");
        pop_none("uf_2");
        reg_read("alias_0x10", 8'h10, 32'h1000);
`endif

        // Reset mid-operation
        reg_write(8'hC, 32'h2);
        wait_req("r3_req0", 31'h1000);
        core_rst_b = 1'b0;
        #1;
        check("midrst_outputs", {dmac__fsabo_valid, data_ready, data[61:0]}, 64'h0);
        @(negedge core_clk);
        core_rst_b = 1'b1;
        @(negedge core_clk);
        send_beats(4'h3, 4'h5, 64'h500, 8);
        reg_read("midrst_control", 8'hC, 32'h1);
        reg_read("midrst_cur", 8'h8, 32'h0);
        pop_none("midrst_no_data");
        idle_none("midrst_no_req", 10);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
